instr_encoder: RTL

Inverse of the immediate generator: accepts decoded instruction fields plus a signed 32-bit immediate, packs them into a 32-bit RV32I word for I-, S- and B-type formats, and streams the words out with sequential word addresses. It sits in front of the instruction-memory write port as the test-program loader and encode/decode loopback source, so ImmGen can be checked against its exact inverse.

---
 rtl/instr_encoder_pkg.sv | 42 ++++
 rtl/instr_pack.sv | 57 +++++
 rtl/instr_encoder.sv | 107 ++++++++++
 3 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder/loader.
// Immediate range limits apply only when INSTR_ENCODER_RANGE_CHECK_EN is defined.
package instr_encoder_pkg;

    localparam logic [1:0] FMT_I   = 2'd0;
    localparam logic [1:0] FMT_S   = 2'd1;
    localparam logic [1:0] FMT_B   = 2'd2;
    localparam logic [1:0] FMT_RSV = 2'd3;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_FULL
    } state_t;

    typedef struct packed {
        logic [1:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } fields_t;

    function automatic logic in_range(input logic [31:0] v,
                                      input int lo,
                                      input int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I I/S/B field packer with reject detection.
// INSTR_ENCODER_RANGE_CHECK_EN adds immediate range/alignment rejection.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  fields_t     f,
    output logic [31:0] instr,
    output logic        reject
);

    logic is_i;
    logic is_s;
    logic is_b;
    logic fmt_bad;
    logic range_bad;

    assign is_i = (f.fmt == FMT_I);
    assign is_s = (f.fmt == FMT_S);
    assign is_b = (f.fmt == FMT_B);

    always_comb begin
        instr   = '0;
        fmt_bad = 1'b0;
        unique case (1'b1)
            is_i: instr = {f.imm[11:0], f.rs1, f.funct3,
                           f.rd, f.opcode};
            is_s: instr = {f.imm[11:5], f.rs2, f.rs1, f.funct3,
                           f.imm[4:0], f.opcode};
            is_b: instr = {f.imm[12], f.imm[10:5], f.rs2, f.rs1,
                           f.funct3, f.imm[4:1], f.imm[11],
                           f.opcode};
            default: fmt_bad = 1'b1;
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    // Branch offsets must also be halfword aligned.
    always_comb begin
        range_bad = 1'b0;
        unique case (1'b1)
            is_i, is_s:
                range_bad = !in_range(f.imm, IMM12_MIN, IMM12_MAX);
            is_b:
                range_bad = !in_range(f.imm, IMM13_MIN, IMM13_MAX)
                            || f.imm[0];
            default: range_bad = 1'b0;
        endcase
    end
`else
    logic imm_hi_unused;
    assign imm_hi_unused = ^f.imm[31:13];
    assign range_bad     = 1'b0;
`endif

    assign reject = fmt_bad | range_bad;

endmodule

// File: rtl/instr_encoder.sv
// Test-program loader: encodes I/S/B field bundles and streams words out.
// Optional immediate range checking via INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 fmt,
    input  logic [6:0]                 opcode,
    input  logic [2:0]                 funct3,
    input  logic [4:0]                 rd,
    input  logic [4:0]                 rs1,
    input  logic [4:0]                 rs2,
    input  logic [31:0]                imm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [ADDR_W-1:0]          out_addr,
    output logic                       err,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t      state;
    fields_t     fin;
    logic [31:0] packed_w;
    logic        rejected;
    logic [CW-1:0] count_inc;

    assign fin.fmt    = fmt;
    assign fin.opcode = opcode;
    assign fin.funct3 = funct3;
    assign fin.rd     = rd;
    assign fin.rs1    = rs1;
    assign fin.rs2    = rs2;
    assign fin.imm    = imm;

    instr_pack u_pack (
        .f      (fin),
        .instr  (packed_w),
        .reject (rejected)
    );

    assign count_inc = count + CW'(1);

    // Handshake flags are registered alongside the state so every
    // output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= '0;
            err       <= 1'b0;
            full      <= 1'b0;
            count     <= '0;
        end else begin
            err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (rejected) begin
                            err <= 1'b1;
                        end else begin
                            out_instr <= packed_w;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        count     <= count_inc;
                        out_addr  <= out_addr + ADDR_W'(4);
                        out_valid <= 1'b0;
                        if (count_inc == CW'(DEPTH)) begin
                            full  <= 1'b1;
                            state <= ST_FULL;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    end
                end
                ST_FULL: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    full      <= 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
